rv32i_mem_arbiter: RTL and testbench



---
 rtl/rv32i_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// Arbiter sharing one synchronous memory between fetch and data ports.
// Optional statistics counters: define RV32I_MEM_ARB_STATS_EN.
module rv32i_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
`ifdef RV32I_MEM_ARB_STATS_EN
  ,
  parameter int STAT_W     = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_ena,
  input  logic [DATA_W-1:0] mem_rd_data
`ifdef RV32I_MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_i_grants,
  output logic [STAT_W-1:0] stat_conflicts
`endif
);

  localparam logic [0:0] DATA_PRI  = 1'b0;
  localparam logic [0:0] INSTR_PRI = 1'b1;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [3:0] MAXS = 4'(MAX_STARVE);

  logic [0:0]        pri_q, pri_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        own_q, own_d;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // Grants are held low during reset so every output reads zero.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (ena && !rst) begin
      if (pri_q == INSTR_PRI) begin
        i_gnt = i_req;
        d_gnt = d_req & ~i_req;
      end else begin
        d_gnt = d_req;
        i_gnt = i_req & ~d_req;
      end
    end
  end

  assign mem_addr    = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
  assign mem_wr_data = d_gnt ? d_wdata : '0;
  assign mem_wr_ena  = d_gnt & d_we;

  always_comb begin
    pri_d = pri_q;
    cnt_d = cnt_q;
    if (ena) begin
      if (i_gnt) begin
        pri_d = DATA_PRI;
        cnt_d = '0;
      end else begin
        if (cnt_q == MAXS) pri_d = INSTR_PRI;
        if (!i_req)              cnt_d = '0;
        else if (cnt_q != MAXS)  cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    own_d = OWN_NONE;
    if (i_gnt)              own_d = OWN_I;
    else if (d_gnt && !d_we) own_d = OWN_D;
  end

  assign i_rvalid = (own_q == OWN_I);
  assign d_rvalid = (own_q == OWN_D);
  assign i_rdata  = i_rvalid ? mem_rd_data : i_rdata_q;
  assign d_rdata  = d_rvalid ? mem_rd_data : d_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_q     <= DATA_PRI;
      cnt_q     <= '0;
      own_q     <= OWN_NONE;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      pri_q <= pri_d;
      cnt_q <= cnt_d;
      own_q <= own_d;
      if (i_rvalid) i_rdata_q <= mem_rd_data;
      if (d_rvalid) d_rdata_q <= mem_rd_data;
    end
  end

`ifdef RV32I_MEM_ARB_STATS_EN
  logic [STAT_W-1:0] igr_q, cfl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      igr_q <= '0;
      cfl_q <= '0;
    end else if (ena) begin
      if (i_gnt)         igr_q <= igr_q + 1'b1;
      if (i_req && d_req) cfl_q <= cfl_q + 1'b1;
    end
  end

  assign stat_i_grants  = igr_q;
  assign stat_conflicts = cfl_q;
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter with a shadow memory model.
// Stats ports are checked when RV32I_MEM_ARB_STATS_EN is defined.
module tb_rv32i_mem_arbiter;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_wr_ena;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wr_data;
  logic [31:0] mem_rd_data = '0;
`ifdef RV32I_MEM_ARB_STATS_EN
  logic [31:0] stat_i_grants, stat_conflicts;
`endif

  rv32i_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_STARVE(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ena(mem_wr_ena), .mem_rd_data(mem_rd_data)
`ifdef RV32I_MEM_ARB_STATS_EN
    ,
    .stat_i_grants(stat_i_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory device seen by the DUT, and the bench's own shadow copy.
  logic [31:0] tbmem  [0:255];
  logic [31:0] refmem [0:255];

  always @(posedge clk) begin
    mem_rd_data <= tbmem[mem_addr[9:2]];
    if (mem_wr_ena) tbmem[mem_addr[9:2]] = mem_wr_data;
  end

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  rsp_t        iq[$];
  rsp_t        dq[$];
  logic [31:0] exp_ird = '0;
  logic [31:0] exp_drd = '0;

  // Fairness bookkeeping: length of the current run of refused fetches
  // and whether fetch has earned the next contested slot.
  int  denied = 0;
  bit  instr_turn = 1'b0;
  bit  pend_i = 1'b0;
  bit  pend_d = 1'b0;
  bit  last_ig = 1'b0;
  int  exp_igr = 0;
  int  exp_cfl = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit ev_i, ev_d;
    if (!rst) begin
      ev_i = (iq.size() > 0) && (iq[0].cyc == cyc);
      ev_d = (dq.size() > 0) && (dq[0].cyc == cyc);
      chk("i_rvalid", {31'b0, i_rvalid}, {31'b0, ev_i});
      chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, ev_d});
      if (ev_i) begin
        exp_ird = iq[0].data;
        void'(iq.pop_front());
      end
      if (ev_d) begin
        exp_drd = dq[0].data;
        void'(dq.pop_front());
      end
      chk("i_rdata", i_rdata, exp_ird);
      chk("d_rdata", d_rdata, exp_drd);
    end
  end

  task automatic step();
    bit eg_i, eg_d;
    logic [31:0] ea;
    @(negedge clk);
`ifdef RV32I_MEM_ARB_STATS_EN
    chk("stat_i_grants", stat_i_grants, exp_igr);
    chk("stat_conflicts", stat_conflicts, exp_cfl);
`endif
    eg_i = 1'b0;
    eg_d = 1'b0;
    if (ena) begin
      if (instr_turn) begin
        eg_i = i_req;
        eg_d = d_req && !i_req;
      end else begin
        eg_d = d_req;
        eg_i = i_req && !d_req;
      end
    end
    ea = eg_d ? d_addr : (eg_i ? i_addr : 32'h0);
    chk("i_gnt", {31'b0, i_gnt}, {31'b0, eg_i});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
    chk("mem_addr", mem_addr, ea);
    chk("mem_wr_ena", {31'b0, mem_wr_ena}, {31'b0, eg_d && d_we});
    if (eg_d && d_we) chk("mem_wr_data", mem_wr_data, d_wdata);
    if (eg_i) iq.push_back('{cyc + 1, refmem[i_addr[9:2]]});
    if (eg_d && !d_we) dq.push_back('{cyc + 1, refmem[d_addr[9:2]]});
    if (eg_d && d_we) refmem[d_addr[9:2]] = d_wdata;
    if (ena) begin
      if (eg_i) begin
        denied = 0;
        instr_turn = 1'b0;
      end else begin
        if (denied == MAXS) instr_turn = 1'b1;
        if (!i_req) denied = 0;
        else if (denied < MAXS) denied = denied + 1;
      end
      if (eg_i) exp_igr++;
      if (i_req && d_req) exp_cfl++;
    end
    last_ig = eg_i;
    pend_i = i_req && !eg_i;
    pend_d = d_req && !eg_d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_i_gnt"}, {31'b0, i_gnt}, 32'h0);
    chk({tag, "_d_gnt"}, {31'b0, d_gnt}, 32'h0);
    chk({tag, "_i_rvalid"}, {31'b0, i_rvalid}, 32'h0);
    chk({tag, "_d_rvalid"}, {31'b0, d_rvalid}, 32'h0);
    chk({tag, "_i_rdata"}, i_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk({tag, "_mem_wr_ena"}, {31'b0, mem_wr_ena}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
`ifdef RV32I_MEM_ARB_STATS_EN
    chk({tag, "_stat_i_grants"}, stat_i_grants, 32'h0);
    chk({tag, "_stat_conflicts"}, stat_conflicts, 32'h0);
`endif
  endtask

  task automatic rand_drive();
    ena = ($urandom_range(0, 9) != 0);
    if (pend_i) begin
      if ($urandom_range(0, 7) == 0) i_req = 1'b0;
    end else begin
      i_req  = ($urandom_range(0, 3) != 0);
      i_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b0};
    end
    if (pend_d) begin
      if ($urandom_range(0, 7) == 0) d_req = 1'b0;
    end else begin
      d_req   = ($urandom_range(0, 3) != 0);
      d_we    = $urandom_range(0, 1) == 1;
      d_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b0};
      d_wdata = $urandom;
    end
  endtask

  initial begin
    int win;
    for (int k = 0; k < 256; k++) begin
      tbmem[k]  = $urandom;
      refmem[k] = tbmem[k];
    end
    tbmem[4]  = 32'h00500093;
    refmem[4] = 32'h00500093;

    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    ena = 1'b1;

    // Starvation: both ports held; fetch wins only in cycle 5.
    i_req = 1'b1; i_addr = 32'h14;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    win = -1;
    for (int k = 0; k < 7; k++) begin
      step();
      if (last_ig && win < 0) win = k;
    end
    chk("starve_win_cycle", win, 32'd5);
`ifdef RV32I_MEM_ARB_STATS_EN
    @(negedge clk);
    chk("stat_conflicts_7", stat_conflicts, 32'd7);
    @(posedge clk);
    #1;
`endif
    idle();
    step();
    step();

    // Fetch only.
    i_req = 1'b1; i_addr = 32'h10;
    step();
    idle();
    step();
    chk("fetch_rdata", i_rdata, 32'h00500093);

    // Data write then read-back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    step();
    idle();
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    step();
    idle();
    step();
    chk("wr_readback", d_rdata, 32'hDEADBEEF);

    // Back-to-back data read then fetch.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    step();
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 32'h14;
    step();
    idle();
    step();
    step();

    // Grant a read then drop ena with both ports requesting.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    step();
    ena = 1'b0;
    i_req = 1'b1; i_addr = 32'h18;
    for (int k = 0; k < 3; k++) step();
    ena = 1'b1;
    for (int k = 0; k < 7; k++) step();
    idle();
    step();

    // Reset in the response cycle of a granted read.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    step();
    rst = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    iq.delete(); dq.delete();
    exp_ird = '0; exp_drd = '0;
    denied = 0; instr_turn = 1'b0;
    exp_igr = 0; exp_cfl = 0;
    pend_i = 1'b0; pend_d = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    step();

    // Five conflict cycles after reset.
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    for (int k = 0; k < 5; k++) step();
    idle();
`ifdef RV32I_MEM_ARB_STATS_EN
    @(negedge clk);
    chk("stat_conflicts_5", stat_conflicts, 32'd5);
    @(posedge clk);
    #1;
`endif
    step();

    for (int k = 0; k < 2000; k++) begin
      rand_drive();
      step();
    end
    idle();
    ena = 1'b1;
    step();
    step();
    chk("iq_drained", iq.size(), 32'd0);
    chk("dq_drained", dq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
